// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall vector generation, multi-cycle EX sequencing and
// exception/return flush redirect for the five-stage core.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

module pipeline_ctrl #(
  parameter int MULT_CYCLES = 3,
  parameter int DIV_CYCLES  = 34,
  parameter int CNT_WIDTH   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_id,
  input  logic              ex_mc_start,
  input  logic              ex_mc_op,
  input  logic              stall_req_mem,
  input  logic              flush_req,
  input  logic [`ADDR_BUS]  flush_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [`ADDR_BUS]  new_pc,
  output logic              ex_mc_done,
  output logic              ex_busy
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Loaded on acceptance; the accept cycle itself and the done cycle are not counted.
  localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES - 2);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ex_req;
  logic                 w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ex_req    = 1'b0;
    w_done      = 1'b0;
    if (flush_req) begin
      // Flush aborts any op in flight and suppresses a same-cycle start.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_mc_start) begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = ex_mc_op ? DIV_LOAD : MULT_LOAD;
            w_ex_req    = 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            w_ex_req  = 1'b1;
            w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
          end else begin
            // Result stays valid until MEM can take the instruction.
            w_done = 1'b1;
            if (!stall_req_mem) w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (flush_req)          stall = 6'b000000;
    else if (stall_req_mem) stall = 6'b011111;
    else if (w_ex_req)      stall = 6'b001111;
    else if (stall_req_id)  stall = 6'b000111;
  end

  assign flush      = flush_req;
  assign new_pc     = flush_req ? flush_pc : '0;
  assign ex_mc_done = w_done;
  assign ex_busy    = (r_state == S_BUSY);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with constant
// expectations, then random traffic against a cycle-indexed reference model.
module tb_pipeline_ctrl;

  localparam int MULT = 3;
  localparam int DIV  = 34;

  logic        clk = 1'b0;
  logic        rst, stall_req_id, ex_mc_start, ex_mc_op, stall_req_mem, flush_req;
  logic [31:0] flush_pc, new_pc;
  logic [5:0]  stall;
  logic        flush, ex_mc_done, ex_busy;

  int checks = 0;
  int fails  = 0;

  // Reference model: an accepted op finishes at an absolute cycle number.
  bit   m_active;
  int   m_end;
  int   cyc;
  logic [5:0]  e_stall;
  logic [31:0] e_pc;
  logic        e_flush, e_done, e_busy;

  pipeline_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .stall_req_id(stall_req_id), .ex_mc_start(ex_mc_start),
    .ex_mc_op(ex_mc_op), .stall_req_mem(stall_req_mem), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_mc_done(ex_mc_done), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  // Apply inputs just after a rising edge, then wait for the falling edge to sample.
  task automatic drive(input logic r, input logic id, input logic st, input logic op,
                       input logic mem, input logic fl, input logic [31:0] pc);
    rst = r; stall_req_id = id; ex_mc_start = st; ex_mc_op = op;
    stall_req_mem = mem; flush_req = fl; flush_pc = pc;
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, $urandom);
      nxt();
    end
    drive(1'b0, 0, 0, 0, 0, 0, 32'h0);
    checks += 5;
    if (stall !== 6'b0)    begin fails++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    if (flush !== 1'b0)    begin fails++; $display("FAIL reset_flush got=%b exp=0", flush); end
    if (new_pc !== 32'h0)  begin fails++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    if (ex_mc_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", ex_mc_done); end
    if (ex_busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got=%b exp=0", ex_busy); end
    nxt();
  endtask

  task automatic test_id_hazard();
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    checks += 2;
    if (stall !== 6'b000111) begin fails++; $display("FAIL id_stall got=%b exp=000111", stall); end
    if (ex_busy !== 1'b0)    begin fails++; $display("FAIL id_busy got=%b exp=0", ex_busy); end
    nxt();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    checks += 2;
    if (stall !== 6'b000000) begin fails++; $display("FAIL id_release got=%b exp=000000", stall); end
    if (ex_busy !== 1'b0)    begin fails++; $display("FAIL id_busy_after got=%b exp=0", ex_busy); end
    nxt();
  endtask

  task automatic test_divide();
    int n_stall = 0;
    int done_at = -1;
    for (int c = 0; c < DIV; c++) begin
      drive(0, 0, 1, 1, 0, 0, 32'h0);
      if (stall === 6'b001111) n_stall++;
      if (ex_mc_done === 1'b1 && done_at < 0) done_at = c;
      checks += 3;
      if (stall !== ((c < DIV-1) ? 6'b001111 : 6'b000000)) begin
        fails++; $display("FAIL div_stall c=%0d got=%b", c, stall); end
      if (ex_mc_done !== (c == DIV-1)) begin
        fails++; $display("FAIL div_done c=%0d got=%b exp=%b", c, ex_mc_done, c == DIV-1); end
      if (ex_busy !== (c >= 1)) begin
        fails++; $display("FAIL div_busy c=%0d got=%b exp=%b", c, ex_busy, c >= 1); end
      nxt();
    end
    checks += 2;
    if (n_stall != DIV-1) begin fails++; $display("FAIL div_stall_count got=%0d exp=%0d", n_stall, DIV-1); end
    if (done_at != DIV-1) begin fails++; $display("FAIL div_done_cycle got=%0d exp=%0d", done_at, DIV-1); end
    // Back-to-back multiply accepted in the very next cycle.
    for (int c = 0; c < MULT; c++) begin
      drive(0, 0, 1, 0, 0, 0, 32'h0);
      checks += 3;
      if (stall !== ((c < MULT-1) ? 6'b001111 : 6'b000000)) begin
        fails++; $display("FAIL b2b_stall c=%0d got=%b", c, stall); end
      if (ex_mc_done !== (c == MULT-1)) begin
        fails++; $display("FAIL b2b_done c=%0d got=%b", c, ex_mc_done); end
      if (ex_busy !== (c >= 1)) begin
        fails++; $display("FAIL b2b_busy c=%0d got=%b", c, ex_busy); end
      nxt();
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (ex_busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%b exp=0", ex_busy); end
    nxt();
  endtask

  task automatic test_mult_mem();
    logic [5:0] xs [6] = '{6'h0f, 6'h0f, 6'h1f, 6'h1f, 6'h00, 6'h00};
    logic       xd [6] = '{0, 0, 1, 1, 1, 0};
    logic       xb [6] = '{0, 1, 1, 1, 1, 0};
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, c < 5, 0, (c == 2 || c == 3), 0, 32'h0);
      checks += 3;
      if (stall !== xs[c])      begin fails++; $display("FAIL mm_stall c=%0d got=%b exp=%b", c, stall, xs[c]); end
      if (ex_mc_done !== xd[c]) begin fails++; $display("FAIL mm_done c=%0d got=%b exp=%b", c, ex_mc_done, xd[c]); end
      if (ex_busy !== xb[c])    begin fails++; $display("FAIL mm_busy c=%0d got=%b exp=%b", c, ex_busy, xb[c]); end
      nxt();
    end
  endtask

  task automatic test_flush_div();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 1, 0, 0, 32'h0);
      checks++;
      if (ex_mc_done !== 1'b0) begin fails++; $display("FAIL fd_early_done c=%0d got=%b", c, ex_mc_done); end
      nxt();
    end
    drive(0, 0, 1, 1, 0, 1, 32'hBFC00380);
    checks += 4;
    if (flush !== 1'b1)           begin fails++; $display("FAIL fd_flush got=%b exp=1", flush); end
    if (new_pc !== 32'hBFC00380)  begin fails++; $display("FAIL fd_new_pc got=%h exp=bfc00380", new_pc); end
    if (stall !== 6'b0)           begin fails++; $display("FAIL fd_stall got=%b exp=000000", stall); end
    if (ex_mc_done !== 1'b0)      begin fails++; $display("FAIL fd_done got=%b exp=0", ex_mc_done); end
    nxt();
    // Restart: a full divide count from scratch.
    for (int c = 0; c < DIV; c++) begin
      drive(0, 0, 1, 1, 0, 0, 32'h0);
      checks += 2;
      if (ex_busy !== (c >= 1)) begin fails++; $display("FAIL fd_re_busy c=%0d got=%b", c, ex_busy); end
      if (ex_mc_done !== (c == DIV-1)) begin fails++; $display("FAIL fd_re_done c=%0d got=%b", c, ex_mc_done); end
      if (c == 0) begin
        checks += 2;
        if (flush !== 1'b0)   begin fails++; $display("FAIL fd_re_flush got=%b exp=0", flush); end
        if (new_pc !== 32'h0) begin fails++; $display("FAIL fd_re_new_pc got=%h exp=0", new_pc); end
      end
      nxt();
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    nxt();
  endtask

  task automatic test_flush_done_mem();
    logic [31:0] pc = $urandom;
    drive(0, 0, 1, 0, 0, 0, 32'h0); nxt();
    drive(0, 0, 1, 0, 0, 0, 32'h0); nxt();
    drive(0, 0, 1, 0, 1, 1, pc);
    checks += 4;
    if (flush !== 1'b1)      begin fails++; $display("FAIL fdm_flush got=%b exp=1", flush); end
    if (stall !== 6'b0)      begin fails++; $display("FAIL fdm_stall got=%b exp=000000", stall); end
    if (ex_mc_done !== 1'b0) begin fails++; $display("FAIL fdm_done got=%b exp=0", ex_mc_done); end
    if (new_pc !== pc)       begin fails++; $display("FAIL fdm_new_pc got=%h exp=%h", new_pc, pc); end
    nxt();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    checks += 2;
    if (ex_busy !== 1'b0)    begin fails++; $display("FAIL fdm_idle got=%b exp=0", ex_busy); end
    if (ex_mc_done !== 1'b0) begin fails++; $display("FAIL fdm_done_after got=%b exp=0", ex_mc_done); end
    nxt();
  endtask

  task automatic model_eval();
    bit exr;
    e_busy = m_active;
    if (flush_req) begin
      e_flush = 1; e_pc = flush_pc; e_stall = 6'b0; e_done = 0;
    end else begin
      e_flush = 0; e_pc = 32'h0;
      exr     = m_active ? (cyc < m_end) : ex_mc_start;
      e_done  = m_active && (cyc >= m_end);
      e_stall = stall_req_mem ? 6'b011111 : exr ? 6'b001111 : stall_req_id ? 6'b000111 : 6'b000000;
    end
  endtask

  task automatic model_next();
    if (rst || flush_req) m_active = 0;
    else if (!m_active && ex_mc_start) begin
      m_active = 1;
      m_end    = cyc + (ex_mc_op ? DIV : MULT) - 1;
    end else if (m_active && cyc >= m_end && !stall_req_mem) m_active = 0;
    cyc++;
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    nxt();
    m_active = 0; cyc = 0;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
            $urandom);
      model_eval();
      checks += 5;
      if (stall !== e_stall)   begin fails++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall, e_stall); end
      if (flush !== e_flush)   begin fails++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, flush, e_flush); end
      if (new_pc !== e_pc)     begin fails++; $display("FAIL rnd_new_pc i=%0d got=%h exp=%h", i, new_pc, e_pc); end
      if (ex_mc_done !== e_done) begin fails++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, ex_mc_done, e_done); end
      if (ex_busy !== e_busy)  begin fails++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, ex_busy, e_busy); end
      model_next();
      nxt();
    end
  endtask

  initial begin
    rst = 1; stall_req_id = 0; ex_mc_start = 0; ex_mc_op = 0;
    stall_req_mem = 0; flush_req = 0; flush_pc = 32'h0;
    nxt();
    test_reset();
    test_id_hazard();
    test_divide();
    test_mult_mem();
    test_flush_div();
    test_flush_done_mem();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control unit for the five-stage CPU. It turns per-stage stall requests into the stall vector that holds the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences multi-cycle EX operations (multiply and divide) with an occupancy counter, holding the pipeline until the result is ready. It also handles exception/return flushes, which take priority over everything else and abort any multi-cycle operation in progress.

## Interface
Parameters:
- MULT_CYCLES, 3: total EX residency of a multiply, in cycles. Must be ≥2.
- DIV_CYCLES, 34: total EX residency of a divide, in cycles. Must be ≥2.
- CNT_WIDTH, 6: occupancy counter width. Must satisfy 2^CNT_WIDTH > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_req_id  in  1  load-use hazard request from ID.
- ex_mc_start  in  1  a multi-cycle op occupies EX; level signal, stays high while that instruction is in EX.
- ex_mc_op  in  1  0 = multiply, 1 = divide; valid while ex_mc_start is high.
- stall_req_mem  in  1  MEM bus not ready.
- flush_req  in  1  exception/eret flush request from MEM.
- flush_pc  in  `ADDR_BUS  flush target address.
- stall  out  6  stall vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush  out  1  clear all pipeline registers.
- new_pc  out  `ADDR_BUS  redirect PC, valid while flush is high.
- ex_mc_done  out  1  multi-cycle result valid; EX captures it this cycle.
- ex_busy  out  1  FSM is in BUSY.

## Operation
- FSM states: IDLE and BUSY. A CNT_WIDTH-bit counter, cnt, runs alongside.
- IDLE with ex_mc_start=1 and flush_req=0:
  - Load cnt with (ex_mc_op ? DIV_CYCLES : MULT_CYCLES) − 2.
  - Go to BUSY.
  - Raise the EX stall request in this cycle.
- BUSY with cnt≠0:
  - Raise the EX stall request.
  - Decrement cnt.
- BUSY with cnt=0:
  - ex_mc_done=1; no EX stall request.
  - If stall_req_mem=0, go to IDLE.
  - Otherwise stay in BUSY with cnt=0, holding ex_mc_done high until MEM releases.
- ex_mc_start is ignored outside IDLE.
- Stall vector encoding; the highest requesting stage wins:
  - stall_req_mem → 6'b011111
  - EX request → 6'b001111
  - stall_req_id → 6'b000111
  - no request → 6'b000000
- flush_req=1 has top priority, in any state:
  - flush=1, new_pc=flush_pc, stall=0.
  - ex_mc_done is forced to 0.
  - Next state is IDLE with cnt=0, and ex_mc_start is not accepted that cycle.
- When flush=0, new_pc=0.
- rst=1: state IDLE, cnt=0.

## Timing
- stall, flush, new_pc and ex_mc_done are combinational from the current state and inputs, with zero-cycle latency. ex_busy is combinational from state only.
- Reset values: with inputs low, every output is 0.
- A multi-cycle op with residency N, starting in cycle 0:
  - stall[3:0]=1111 in cycles 0..N−2 (N−1 cycles).
  - ex_mc_done=1 in cycle N−1.
  - The instruction enters EX/MEM at the end of cycle N−1, absent a MEM stall.
- A new op arriving in EX in cycle N (IDLE again) is accepted that same cycle; there are no dead cycles between back-to-back ops.
- stall_req_mem during counting: cnt keeps decrementing. The vector shows 011111; the completion cycle is unchanged, but done is held until release.
- Flush in the same cycle as completion: flush wins and done=0.
- rst mid-BUSY: IDLE on the next edge, with no done pulse.

## Test plan
- Reset:
  - Stimulus: assert rst with random inputs, then deassert with inputs 0.
  - Required: stall=0, flush=0, new_pc=0, ex_mc_done=0, ex_busy=0.
- ID hazard only:
  - Stimulus: stall_req_id=1 for 1 cycle.
  - Required: stall=000111 that cycle only; ex_busy stays 0.
- Divide, DIV_CYCLES=34:
  - Stimulus: ex_mc_start=1, ex_mc_op=1 held until done.
  - Required: stall=001111 for 33 cycles; ex_mc_done=1 in cycle 33 with stall=0; ex_busy=1 in cycles 1..33.
  - Follow-up: a multiply started in cycle 34 is accepted immediately.
- Multiply with MEM stall at completion, MULT_CYCLES=3:
  - Stimulus: stall_req_mem=1 in cycles 2..3.
  - Required: stall=001111 in cycles 0..1; stall=011111 with ex_mc_done=1 in cycles 2..3; done=1 with stall=0 in cycle 4; IDLE in cycle 5.
- Flush during divide:
  - Stimulus: flush_req=1 in cycle 5 with flush_pc=0xBFC00380.
  - Required: in cycle 5, flush=1, new_pc=0xBFC00380, stall=0; IDLE in cycle 6; ex_mc_done is never asserted.
  - Follow-up: a fresh ex_mc_start in cycle 6 restarts the full count.
- Flush coinciding with completion and MEM stall:
  - Stimulus: flush_req=1 in the cycle where cnt=0 and stall_req_mem=1.
  - Required: flush=1, stall=0, ex_mc_done=0; IDLE next cycle.
